ro_freq_meter: RTL and testbench

- Multi-channel ring-oscillator frequency meter. Successor to the single-channel counting circuit in the RO characterisation top level.
- Samples NCH asynchronous ring/prescaled-ring outputs and counts rising edges of one selected channel over a fixed gate window of clk cycles.
- Supports single-shot and continuous modes, with a settle window after each channel switch.
- Delivers a saturating CNT_W result with channel tag and valid pulse to the display interface.

---
 rtl/ro_meter_pkg.sv | 30 +++
 rtl/ro_freq_meter_if.sv | 38 +++
 rtl/ro_edge_sync.sv | 41 ++++
 rtl/ro_freq_meter.sv | 178 +++++++++++++++++
 tb/tb_ro_freq_meter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ro_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ro_meter_pkg
// Description : Shared types, default constants and helpers for the
//               ring-oscillator frequency meter.
// Revision    : 1.0 - initial release
// ============================================================================
package ro_meter_pkg;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } meter_state_e;

  localparam int unsigned DEF_NCH        = 4;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_GATE_CYC   = 50000;
  localparam int unsigned DEF_SETTLE_CYC = 16;

  // Increment that sticks at max instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] count,
                                          input logic [31:0] max);
    return (count >= max) ? max : count + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ro_freq_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : ro_freq_meter_if
// Description : Control/result bundle between a display/controller (master)
//               and the frequency meter (slave).
//               Optional macro RO_MIN_HOLD_EN adds min_out / min_clr.
// Revision    : 1.0 - initial release
// ============================================================================
interface ro_freq_meter_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) ();
  localparam int SEL_W = $clog2(NCH);

  logic [SEL_W-1:0] ch_sel;
  logic             start;
  logic             continuous;
  logic             busy;
  logic [CNT_W-1:0] value_out;
  logic [SEL_W-1:0] value_ch;
  logic             value_valid;
  logic             overflow;
`ifdef RO_MIN_HOLD_EN
  logic [CNT_W-1:0] min_out;
  logic             min_clr;

  modport master (output ch_sel, start, continuous, min_clr,
                  input  busy, value_out, value_ch, value_valid, overflow, min_out);
  modport slave  (input  ch_sel, start, continuous, min_clr,
                  output busy, value_out, value_ch, value_valid, overflow, min_out);
`else
  modport master (output ch_sel, start, continuous,
                  input  busy, value_out, value_ch, value_valid, overflow);
  modport slave  (input  ch_sel, start, continuous,
                  output busy, value_out, value_ch, value_valid, overflow);
`endif
endinterface
`default_nettype wire

// File: rtl/ro_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : ro_edge_sync
// Description : Two-flop synchronizer for one asynchronous ring output plus a
//               history flop; edge_pulse marks a synchronized rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ring_in,
  output logic edge_pulse
);
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Shift the raw input down the synchronizer/history chain
  always_comb begin
    sync1_d = ring_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Chain registers; cleared so no spurious edge follows reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign edge_pulse = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/ro_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : ro_freq_meter
// Description : Multi-channel ring-oscillator frequency meter. Counts rising
//               edges of one selected channel over a fixed gate window, with
//               a settle window after each channel (re)selection.
//               Optional macro RO_MIN_HOLD_EN adds a minimum-result tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int NCH        = DEF_NCH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GATE_CYC   = DEF_GATE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ring_in,
  ro_freq_meter_if.slave    bus
);
  localparam int SEL_W = $clog2(NCH);
  localparam int GC_W  = $clog2(GATE_CYC + 1);
  localparam int SC_W  = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NCH-1:0]   edge_vec;
  logic [SEL_W-1:0] sel_legal;
  logic             pulse;

  meter_state_e     state_q,     state_d;
  logic [SEL_W-1:0] cur_ch_q,    cur_ch_d;
  logic [SC_W-1:0]  settle_q,    settle_d;
  logic [GC_W-1:0]  gate_q,      gate_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic             sat_q,       sat_d;
  logic [CNT_W-1:0] value_out_q, value_out_d;
  logic [SEL_W-1:0] value_ch_q,  value_ch_d;
  logic             overflow_q,  overflow_d;
  logic             valid_q,     valid_d;
  logic             busy_q,      busy_d;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      ro_edge_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .ring_in    (ring_in[i]),
        .edge_pulse (edge_vec[i])
      );
    end
  endgenerate

  // Out-of-range selections fall back to channel 0
  assign sel_legal = (int'(bus.ch_sel) >= NCH) ? '0 : bus.ch_sel;
  assign pulse     = edge_vec[cur_ch_q];

  // Sequencer next-state, counters and result capture
  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    settle_d    = settle_q;
    gate_d      = gate_q;
    count_d     = count_q;
    sat_d       = sat_q;
    value_out_d = value_out_q;
    value_ch_d  = value_ch_q;
    overflow_d  = overflow_q;
    valid_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cur_ch_d = sel_legal;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == SC_W'(SETTLE_CYC - 1)) begin
          count_d = '0;
          gate_d  = '0;
          sat_d   = 1'b0;
          state_d = GATE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      GATE: begin
        if (pulse) begin
          if (count_q == CNT_MAX) sat_d = 1'b1;
          count_d = CNT_W'(sat_inc(32'(count_q), 32'(CNT_MAX)));
        end
        gate_d = gate_q + 1'b1;
        // The pulse sampled in this last cycle is already folded into count_d
        if (gate_q == GC_W'(GATE_CYC - 1)) state_d = DONE;
      end
      DONE: begin
        value_out_d = count_q;
        value_ch_d  = cur_ch_q;
        overflow_d  = sat_q;
        valid_d     = 1'b1;
        if (!bus.continuous) begin
          state_d = IDLE;
        end else if (sel_legal == cur_ch_q) begin
          // Same channel: synchronizer history is still valid, skip settling
          count_d = '0;
          gate_d  = '0;
          sat_d   = 1'b0;
          state_d = GATE;
        end else begin
          cur_ch_d = sel_legal;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_ch_q    <= '0;
      settle_q    <= '0;
      gate_q      <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      value_out_q <= '0;
      value_ch_q  <= '0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      settle_q    <= settle_d;
      gate_q      <= gate_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      value_out_q <= value_out_d;
      value_ch_q  <= value_ch_d;
      overflow_q  <= overflow_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.value_out   = value_out_q;
  assign bus.value_ch    = value_ch_q;
  assign bus.value_valid = valid_q;
  assign bus.overflow    = overflow_q;

`ifdef RO_MIN_HOLD_EN
  logic [CNT_W-1:0] min_q, min_d;

  // Track the smallest result; a clear coinciding with a result keeps that result
  always_comb begin
    min_d = min_q;
    if (bus.min_clr && valid_d)    min_d = count_q;
    else if (bus.min_clr)          min_d = '1;
    else if (valid_d && count_q < min_q) min_d = count_q;
  end

  // Minimum holding register, all-ones means no result seen yet
  always_ff @(posedge clk) begin
    if (rst) min_q <= '1;
    else     min_q <= min_d;
  end

  assign bus.min_out = min_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ro_freq_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ro_freq_meter
// Description : Scoreboard bench for ro_freq_meter. Two meters (8-bit and
//               4-bit results) share stimulus; expected results come from a
//               waveform-level edge-count model.
//               Optional macro RO_MIN_HOLD_EN adds minimum-tracker checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_freq_meter;
  localparam int NCH    = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_WS = 4;
  localparam int G      = 100;
  localparam int S      = 4;
  localparam int MAX8   = 255;
  localparam int MAX4   = 15;

  typedef struct {
    int r;
    int ch;
    int cnt;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] ring_in = '0;
  logic           min_clr_drv = 1'b0;
  int             cyc = 0;
  int             per [NCH];
  int             ph  [NCH];
  exp_t           q   [$];
  exp_t           qs  [$];
  int             checks = 0;
  int             failures = 0;

  always #5 clk = ~clk;

  ro_freq_meter_if #(.NCH(NCH), .CNT_W(CNT_W))  bus   ();
  ro_freq_meter_if #(.NCH(NCH), .CNT_W(CNT_WS)) bus_s ();

  assign bus_s.start      = bus.start;
  assign bus_s.ch_sel     = bus.ch_sel;
  assign bus_s.continuous = bus.continuous;
`ifdef RO_MIN_HOLD_EN
  assign bus.min_clr      = min_clr_drv;
  assign bus_s.min_clr    = min_clr_drv;
`endif

  ro_freq_meter #(.NCH(NCH), .CNT_W(CNT_W), .GATE_CYC(G), .SETTLE_CYC(S)) u_dut (
    .clk(clk), .rst(rst), .ring_in(ring_in), .bus(bus));

  ro_freq_meter #(.NCH(NCH), .CNT_W(CNT_WS), .GATE_CYC(G), .SETTLE_CYC(S)) u_sat (
    .clk(clk), .rst(rst), .ring_in(ring_in), .bus(bus_s));

  // Edge counter: cyc equals the index of the most recent rising clk edge
  always @(posedge clk) cyc <= cyc + 1;

  // Square wave of channel ch as seen at clk edge e
  function automatic bit wave(input int ch, input int e);
    if (e < 0) return 1'b0;
    return ((e + ph[ch]) % per[ch]) < (per[ch] / 2);
  endfunction

  // Drive ring inputs for the next rising edge
  always @(negedge clk) begin
    for (int ch = 0; ch < NCH; ch++) ring_in[ch] = wave(ch, cyc + 1);
  end

  // Input rises whose pulse reaches the counter at edges lo..hi
  // (a rise first sampled at edge k is counted at edge k+2)
  function automatic int exp_cnt(input int ch, input int lo, input int hi);
    int n = 0;
    for (int e = lo; e <= hi; e++)
      if (wave(ch, e - 2) && !wave(ch, e - 3)) n++;
    return n;
  endfunction

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Expected result at edge r for channel ch; window covers the G edges before r
  function automatic void push(input int r, input int ch);
    exp_t e;
    e.r   = r;
    e.ch  = ch;
    e.cnt = exp_cnt(ch, r - G, r - 1);
    q.push_back(e);
    qs.push_back(e);
  endfunction

  // ---------------------------------------------------------------- monitor
`ifdef RO_MIN_HOLD_EN
  logic clr_smp = 1'b0;
  logic rst_smp = 1'b1;
  int   exp_min = MAX8;
  always @(posedge clk) begin
    clr_smp <= min_clr_drv;
    rst_smp <= rst;
  end
`endif

  always @(negedge clk) begin
    exp_t e;
    exp_t es;
    e.cnt = 0;
    if (bus.value_valid) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result: value_valid at cycle %0d, expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("result_cycle", cyc, e.r);
        chk("value_out", int'(bus.value_out), (e.cnt > MAX8) ? MAX8 : e.cnt);
        chk("value_ch", int'(bus.value_ch), e.ch);
        chk("overflow", int'(bus.overflow), int'(e.cnt > MAX8));
      end
    end
    if (bus_s.value_valid) begin
      if (qs.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result_sat: value_valid at cycle %0d, expected none", cyc);
      end else begin
        es = qs.pop_front();
        chk("sat_result_cycle", cyc, es.r);
        chk("sat_value_out", int'(bus_s.value_out), (es.cnt > MAX4) ? MAX4 : es.cnt);
        chk("sat_value_ch", int'(bus_s.value_ch), es.ch);
        chk("sat_overflow", int'(bus_s.overflow), int'(es.cnt > MAX4));
      end
    end
`ifdef RO_MIN_HOLD_EN
    if (rst_smp)                         exp_min = MAX8;
    else if (clr_smp && bus.value_valid) exp_min = e.cnt;
    else if (clr_smp)                    exp_min = MAX8;
    else if (bus.value_valid && e.cnt < exp_min) exp_min = e.cnt;
    if (bus.value_valid) chk("min_out", int'(bus.min_out), exp_min);
`endif
  end

  // --------------------------------------------------------------- stimulus
  task automatic wait_until(input int t);
    int n = 0;
    while (cyc < t && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (cyc < t) begin
      checks++; failures++;
      $display("FAIL wait_timeout: at cycle %0d expected to reach %0d", cyc, t);
    end
  endtask

  task automatic start_shot(input int ch, input bit cont, output int s0);
    bus.ch_sel     = 2'(ch);
    bus.continuous = cont;
    bus.start      = 1'b1;
    s0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic single(input int ch, input bit clr, input bit poke);
    int s0, r;
    start_shot(ch, 1'b0, s0);
    r = s0 + S + G + 1;
    push(r, ch);
    if (poke) begin
      wait_until(s0 + S + 30);
      bus.ch_sel = 2'(ch + 1);
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
    end
    if (clr) begin
      wait_until(r - 1);
      min_clr_drv = 1'b1;
    end
    wait_until(r);
    min_clr_drv = 1'b0;
    chk("busy_after_result", int'(bus.busy), 0);
    @(negedge clk);
    chk("valid_single_cycle", int'(bus.value_valid), 0);
  endtask

  // Two continuous windows; ch2 is selected mid-way through the first
  task automatic cont2(input int ch, input int ch2);
    int s0, r1, r2;
    start_shot(ch, 1'b1, s0);
    r1 = s0 + S + G + 1;
    push(r1, ch);
    r2 = (ch2 == ch) ? r1 + G + 1 : r1 + S + G + 1;
    push(r2, ch2);
    wait_until(r1 - 50);
    bus.ch_sel = 2'(ch2);
    wait_until(r2 - 50);
    bus.continuous = 1'b0;
    wait_until(r2 + 2);
    chk("busy_idle_after_cont", int'(bus.busy), 0);
  endtask

  task automatic set_waves();
    for (int ch = 0; ch < NCH; ch++) begin
      per[ch] = 2 * $urandom_range(2, 20);
      ph[ch]  = $urandom_range(0, 39);
    end
    @(negedge clk);
  endtask

  initial begin
    int s0, r1, r2, r3;
    bus.start = 1'b0;
    bus.ch_sel = '0;
    bus.continuous = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      per[ch] = 8;
      ph[ch]  = ch;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_value_out", int'(bus.value_out), 0);
    chk("rst_value_ch", int'(bus.value_ch), 0);
    chk("rst_value_valid", int'(bus.value_valid), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    chk("rst_busy", int'(bus.busy), 0);
`ifdef RO_MIN_HOLD_EN
    chk("rst_min_out", int'(bus.min_out), MAX8);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single shot, channel 2 at period 10
    per[2] = 10; ph[2] = 3;
    @(negedge clk);
    single(2, 1'b0, 1'b0);

    // Saturating window, then a slow one on the same channel
    per[1] = 4; ph[1] = 1;
    @(negedge clk);
    single(1, 1'b0, 1'b0);
    per[1] = 40; ph[1] = 7;
    @(negedge clk);
    single(1, 1'b0, 1'b0);

    // Start while busy is ignored
    single(2, 1'b0, 1'b1);

    // Continuous: two windows on ch0, switch to ch3 during the second
    per[0] = 20; ph[0] = 0;
    per[3] = 10; ph[3] = 4;
    @(negedge clk);
    start_shot(0, 1'b1, s0);
    r1 = s0 + S + G + 1;
    r2 = r1 + G + 1;
    r3 = r2 + S + G + 1;
    push(r1, 0);
    push(r2, 0);
    push(r3, 3);
    wait_until(r1 + 20);
    bus.ch_sel = 2'd3;
    wait_until(r2 + 30);
    bus.continuous = 1'b0;
    wait_until(r3 + 1);
    chk("busy_idle_after_switch", int'(bus.busy), 0);

    // Reset at gate cycle 50 aborts the measurement
    start_shot(1, 1'b0, s0);
    wait_until(s0 + S + 50);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_value_out", int'(bus.value_out), 0);
    chk("abort_value_ch", int'(bus.value_ch), 0);
    chk("abort_value_valid", int'(bus.value_valid), 0);
    chk("abort_overflow", int'(bus.overflow), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_sat_value_out", int'(bus_s.value_out), 0);
    rst = 1'b0;
    repeat (150) @(negedge clk);

    // Randomized windows
    for (int it = 0; it < 6; it++) begin
      set_waves();
      if ($urandom_range(0, 1) == 0)
        single(int'($urandom_range(0, NCH - 1)), (it == 5), 1'b0);
      else
        cont2(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, NCH - 1)));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size() + qs.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
